wght_acc_ctrl: RTL and testbench
================================

Name: wght_acc_ctrl

Overview:
Sequencer for the weight-gradient accumulator datapath (multiply d·x, accumulate into a register).
- For each weight index it clears the accumulator.
- It then issues one memory read per timestep to fetch d/x operand pairs, and gates the accumulator enable in step with the fixed read latency.
- It pulses a write strobe when the sum for that weight is final.
- It sits between the training-phase top-level controller (start/done) and the d/x operand memories plus the weight-update write port.

Parameters:
ADDR_W, 10, width of weight index / write address
STEP_W, 8, width of timestep counter / operand read address
RD_LAT, 1, cycles from o_rd_en to operand valid at accumulator input (0..7)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (all state cleared while rst=0)
i_start  in  1  one-cycle start request, sampled only in IDLE
i_n_wght  in  ADDR_W  number of weights to process, latched on accepted start
i_n_step  in  STEP_W  number of timesteps per weight, latched on accepted start
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse on job completion
o_rd_en  out  1  operand read strobe
o_t_addr  out  STEP_W  timestep read address
o_w_addr  out  ADDR_W  current weight index (also the write address)
o_acc_clr  out  1  synchronous clear for the accumulator register
o_acc_en  out  1  accumulator enable (mux select: product vs 0)
o_wr_en  out  1  one-cycle strobe: accumulator output is final for o_w_addr

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs are 0. Counters, latched lengths and the RD_LAT enable pipeline are cleared.
- States: IDLE, CLR, ACC, DRAIN, WRITE, DONE.
- IDLE:
  - i_start=1 latches i_n_wght and i_n_step and sets w=0, t=0.
  - Next state is CLR.
  - If either latched length is 0, next state is DONE instead (no reads, no writes).
- CLR: one cycle. o_acc_clr=1, t=0. Next state is ACC.
- ACC:
  - Each cycle: o_rd_en=1, o_t_addr=t, then t++.
  - After the cycle with t=n_step-1, next state is DRAIN (or WRITE if RD_LAT=0).
  - Exactly n_step read cycles per weight.
- o_acc_en is o_rd_en delayed by RD_LAT cycles through a shift register. When RD_LAT=0 it is the same signal.
- The pipeline is not flushed on state change; it also runs through DRAIN.
- DRAIN: exactly RD_LAT cycles with o_rd_en=0. This lets the last product land in the accumulator.
- WRITE:
  - One cycle. o_wr_en=1, o_w_addr=w. The accumulator output equals the full sum over all n_step products.
  - If w=n_wght-1, next state is DONE. Otherwise w++ and next state is CLR.
- DONE: one cycle. o_done=1, o_busy=1. Next state is IDLE.
- o_w_addr holds w in all states and is 0 in IDLE.
- o_t_addr holds its last value outside ACC.
- Per-weight period: n_step+RD_LAT+2 cycles.
- o_done is asserted n_wght·(n_step+RD_LAT+2)+1 cycles after the start-sampling edge.
- i_start while busy is ignored and not queued. Changes to i_n_* while busy are ignored.
- Counter limits: n_step=2^STEP_W−1 and n_wght=2^ADDR_W−1 work without wrap. Counters never exceed n−1.
- Reset mid-job returns to IDLE immediately. No o_done or o_wr_en is issued.

Optional Feature:
WGHT_ACC_CTRL_STALL_EN:
- When defined, adds input port i_stall (1 bit).
- In ACC with i_stall=1: o_rd_en=0 and t is frozen, so no read is issued that cycle.
- The acc_en pipeline keeps shifting, so in-flight operands are still accumulated.
- i_stall is ignored in all other states.
- Each stalled ACC cycle lengthens the per-weight period by one.
- When undefined, there is no port and ACC never pauses.

Test Plan:
1. Default params, n_wght=3, n_step=4, pulse start → 3 CLR pulses; 4 rd_en per weight with t_addr 0,1,2,3; acc_en lags rd_en by 1; wr_en at w=0,1,2; o_done 22 cycles after start edge; busy high throughout.
2. Accumulator model in bench: d=x=0.5 (Q4.20), n_step=4 → value at each wr_en equals 1.0 (0x100000); the previous weight's sum never leaks (clear works).
3. n_wght=0 or n_step=0 → DONE the next cycle after start; no rd_en/wr_en/acc_clr.
4. RD_LAT=0 and RD_LAT=3 builds, n_wght=2, n_step=1 → period 3 and 6 cycles respectively; o_done at 7 and 13 cycles after start.
5. Deassert rst during ACC of w=1 → all outputs 0 asynchronously, IDLE; a new start runs a clean job from w=0.
6. STALL_EN: n_step=4, i_stall high for 2 cycles mid-ACC → t_addr sequence 0,1,1-hold,1-hold,2,3 with rd_en low during the hold; 4 acc_en total; wr_en 2 cycles later than unstalled.

Source files
------------

// File: rtl/wght_acc_ctrl_if.sv
// Control/operand-sequencing bus between wght_acc_ctrl and its surroundings.
// i_stall is present only when WGHT_ACC_CTRL_STALL_EN is defined.
interface wght_acc_ctrl_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned STEP_W = 8
);
  logic              i_start;
  logic [ADDR_W-1:0] i_n_wght;
  logic [STEP_W-1:0] i_n_step;
`ifdef WGHT_ACC_CTRL_STALL_EN
  logic              i_stall;
`endif
  logic              o_busy;
  logic              o_done;
  logic              o_rd_en;
  logic [STEP_W-1:0] o_t_addr;
  logic [ADDR_W-1:0] o_w_addr;
  logic              o_acc_clr;
  logic              o_acc_en;
  logic              o_wr_en;

  modport slave (
    input  i_start, i_n_wght, i_n_step,
`ifdef WGHT_ACC_CTRL_STALL_EN
    input  i_stall,
`endif
    output o_busy, o_done, o_rd_en, o_t_addr, o_w_addr, o_acc_clr, o_acc_en, o_wr_en
  );

  modport master (
    output i_start, i_n_wght, i_n_step,
`ifdef WGHT_ACC_CTRL_STALL_EN
    output i_stall,
`endif
    input  o_busy, o_done, o_rd_en, o_t_addr, o_w_addr, o_acc_clr, o_acc_en, o_wr_en
  );
endinterface

// File: rtl/wght_acc_ctrl.sv
// Weight-gradient accumulator sequencer: clear, n_step reads, drain RD_LAT, write, per weight.
// Optional WGHT_ACC_CTRL_STALL_EN adds i_stall, which pauses reads in ACC.
module wght_acc_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned STEP_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input logic           clk,
  input logic           rst,
  wght_acc_ctrl_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_ACC, S_DRAIN, S_WRITE, S_DONE} state_t;

  localparam logic [2:0] LAT_LAST = 3'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  state_t            state_q;
  logic [ADDR_W-1:0] n_wght_q, w_q;
  logic [STEP_W-1:0] n_step_q, t_q;
  logic [2:0]        lat_q;
  logic              busy_q, done_q, rd_q, clr_q, wr_q;
  logic              stall;
  logic              rd_en;

`ifdef WGHT_ACC_CTRL_STALL_EN
  assign stall = bus.i_stall;
`else
  assign stall = 1'b0;
`endif

  // rd_q marks ACC; a stall masks the strobe in the same cycle and freezes t
  assign rd_en = rd_q & ~stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      n_wght_q <= '0;
      n_step_q <= '0;
      w_q      <= '0;
      t_q      <= '0;
      lat_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_q     <= 1'b0;
      clr_q    <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      clr_q  <= 1'b0;
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.i_start) begin
            n_wght_q <= bus.i_n_wght;
            n_step_q <= bus.i_n_step;
            w_q      <= '0;
            t_q      <= '0;
            busy_q   <= 1'b1;
            if (bus.i_n_wght == '0 || bus.i_n_step == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_CLR;
              clr_q   <= 1'b1;
            end
          end
        end
        S_CLR: begin
          state_q <= S_ACC;
          rd_q    <= 1'b1;
          t_q     <= '0;
        end
        S_ACC: begin
          if (!stall) begin
            if (t_q == n_step_q - STEP_W'(1)) begin
              rd_q <= 1'b0;
              if (RD_LAT == 0) begin
                state_q <= S_WRITE;
                wr_q    <= 1'b1;
              end else begin
                state_q <= S_DRAIN;
                lat_q   <= '0;
              end
            end else begin
              t_q <= t_q + STEP_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (lat_q == LAT_LAST) begin
            state_q <= S_WRITE;
            wr_q    <= 1'b1;
          end else begin
            lat_q <= lat_q + 3'd1;
          end
        end
        S_WRITE: begin
          if (w_q == n_wght_q - ADDR_W'(1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            w_q     <= w_q + ADDR_W'(1);
            state_q <= S_CLR;
            clr_q   <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          w_q     <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          rd_q    <= 1'b0;
        end
      endcase
    end
  end

  // acc_en follows the read strobe by RD_LAT cycles regardless of state
  generate
    if (RD_LAT == 0) begin : g_lat0
      assign bus.o_acc_en = rd_en;
    end else begin : g_lat
      logic [RD_LAT-1:0] pipe_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pipe_q <= '0;
        end else begin
          for (int unsigned i = RD_LAT - 1; i > 0; i--) pipe_q[i] <= pipe_q[i-1];
          pipe_q[0] <= rd_en;
        end
      end
      assign bus.o_acc_en = pipe_q[RD_LAT-1];
    end
  endgenerate

  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;
  assign bus.o_rd_en   = rd_en;
  assign bus.o_t_addr  = t_q;
  assign bus.o_w_addr  = w_q;
  assign bus.o_acc_clr = clr_q;
  assign bus.o_wr_en   = wr_q;
endmodule

// File: tb/tb_wght_acc_ctrl.sv
// Scoreboard bench for wght_acc_ctrl with a Q4.20 d*x accumulator model.
// Stall scenarios run only when WGHT_ACC_CTRL_STALL_EN is defined.
module tb_wght_acc_ctrl;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned STEP_W = 8;
  parameter  int unsigned RD_LAT = 1;
  localparam int BUDGET = 5000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wght_acc_ctrl_if #(.ADDR_W(ADDR_W), .STEP_W(STEP_W)) bus ();
  wght_acc_ctrl #(.ADDR_W(ADDR_W), .STEP_W(STEP_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    int unsigned w;
    logic [31:0] sum;
    int          rel;
  } wr_t;

  wr_t         exp_wr[$];
  int unsigned exp_rd[$];
  int          exp_done[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int t0  = 0;
  bit in_job = 0;
  bit done_seen = 0;
  int n_clr, n_acc, n_wr;
  logic [7:0]  hist;
  logic [31:0] acc;

  // d = x = 0.5 in Q4.20; the product is renormalised back to Q.20
  localparam logic [23:0] HALF_Q = 24'h080000;
  logic [47:0] prod_full;
  logic [31:0] prod;
  assign prod_full = 48'(HALF_Q) * 48'(HALF_Q);
  assign prod      = {8'h00, prod_full[43:20]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst)               acc <= '0;
    else if (bus.o_acc_clr) acc <= '0;
    else if (bus.o_acc_en)  acc <= acc + prod;
  end

  always @(negedge clk) begin
    int  rel;
    int  idx;
    logic exp_acc_en;
    wr_t e;
    if (!rst) begin
      hist = '0;
    end else begin
      rel = cyc - t0 + 1;
      idx = (RD_LAT == 0) ? 0 : int'(RD_LAT) - 1;
      exp_acc_en = (RD_LAT == 0) ? bus.o_rd_en : hist[idx];
      if (bus.o_acc_en || exp_acc_en) check("acc_en_lag", 32'(bus.o_acc_en), 32'(exp_acc_en));
      hist = {hist[6:0], bus.o_rd_en};
      if (bus.o_acc_en)  n_acc++;
      if (bus.o_acc_clr) n_clr++;
      if (bus.o_rd_en) begin
        if (exp_rd.size() == 0) check("rd_extra", 32'd1, 32'd0);
        else check("t_addr", 32'(bus.o_t_addr), 32'(exp_rd.pop_front()));
      end
      if (bus.o_wr_en) begin
        n_wr++;
        if (exp_wr.size() == 0) check("wr_extra", 32'd1, 32'd0);
        else begin
          e = exp_wr.pop_front();
          check("w_addr", 32'(bus.o_w_addr), 32'(e.w));
          check("wr_sum", acc, e.sum);
          check("wr_cycle", 32'(rel), 32'(e.rel));
        end
      end
      if (in_job) check("busy", 32'(bus.o_busy), 32'd1);
      else        check("busy_idle", 32'(bus.o_busy), 32'd0);
      if (bus.o_done) begin
        if (exp_done.size() == 0) check("done_extra", 32'd1, 32'd0);
        else check("done_cycle", 32'(rel), 32'(exp_done.pop_front()));
        in_job    = 0;
        done_seen = 1;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},  32'(bus.o_busy),    32'd0);
    check({tag, "_done"},  32'(bus.o_done),    32'd0);
    check({tag, "_rd"},    32'(bus.o_rd_en),   32'd0);
    check({tag, "_acc"},   32'(bus.o_acc_en),  32'd0);
    check({tag, "_clr"},   32'(bus.o_acc_clr), 32'd0);
    check({tag, "_wr"},    32'(bus.o_wr_en),   32'd0);
    check({tag, "_waddr"}, 32'(bus.o_w_addr),  32'd0);
    check({tag, "_taddr"}, 32'(bus.o_t_addr),  32'd0);
  endtask

  // s0/sl: stall window (relative cycles) inside weight 0; abort_w >= 0 resets mid-job
  task automatic run_job(input int unsigned nw, input int unsigned ns,
                         input int s0, input int sl, input int abort_w);
    int unsigned p;
    int  extra;
    int  rel;
    bit  aborted;
    bit  stall_now;
    p     = ns + RD_LAT + 2;
    extra = (nw > 0 && ns > 0) ? sl : 0;
    if (nw == 0 || ns == 0) begin
      exp_done.push_back(1);
    end else begin
      for (int unsigned w = 0; w < nw; w++) begin
        for (int unsigned t = 0; t < ns; t++) exp_rd.push_back(t);
        exp_wr.push_back('{w, 32'(ns) * 32'h40000, int'((w + 1) * p) + extra});
      end
      exp_done.push_back(int'(nw * p) + extra + 1);
    end
    n_clr = 0; n_acc = 0; n_wr = 0; done_seen = 0;
    @(posedge clk); #1;
    bus.i_start  = 1'b1;
    bus.i_n_wght = ADDR_W'(nw);
    bus.i_n_step = STEP_W'(ns);
    t0 = cyc + 1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    in_job  = 1;
    aborted = 0;
    for (int c = 0; c < BUDGET && !done_seen && !aborted; c++) begin
      rel = cyc - t0 + 1;
      stall_now = (rel >= s0 && rel < s0 + sl);
`ifdef WGHT_ACC_CTRL_STALL_EN
      bus.i_stall = stall_now;
`endif
      // a start and new lengths while busy must be ignored
      bus.i_start = (rel == 3);
      if (rel == 3) bus.i_n_wght = ADDR_W'(nw + 5);
      if (abort_w >= 0 && int'(bus.o_w_addr) == abort_w && bus.o_rd_en) begin
        rst = 1'b0;
        #1;
        check_outputs_zero("rst_async");
        exp_rd.delete(); exp_wr.delete(); exp_done.delete();
        in_job  = 0;
        aborted = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    bus.i_start = 1'b0;
`ifdef WGHT_ACC_CTRL_STALL_EN
    bus.i_stall = 1'b0;
`endif
    if (aborted) begin
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("rst_hold");
      rst = 1'b1;
    end else begin
      if (!done_seen) check("done_timeout", 32'd0, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("rd_left",  32'(exp_rd.size()), 32'd0);
      check("wr_left",  32'(exp_wr.size()), 32'd0);
      check("n_clr",    32'(n_clr), (nw > 0 && ns > 0) ? 32'(nw) : 32'd0);
      check("n_acc_en", 32'(n_acc), 32'(nw * ns));
      check("n_wr",     32'(n_wr),  (nw > 0 && ns > 0) ? 32'(nw) : 32'd0);
      exp_rd.delete(); exp_wr.delete(); exp_done.delete();
      in_job = 0;
    end
  endtask

  initial begin
    bus.i_start  = 1'b0;
    bus.i_n_wght = '0;
    bus.i_n_step = '0;
`ifdef WGHT_ACC_CTRL_STALL_EN
    bus.i_stall  = 1'b0;
`endif
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b1;

    run_job(3, 4, 0, 0, -1);
    run_job(0, 4, 0, 0, -1);
    run_job(2, 0, 0, 0, -1);
    run_job(2, 1, 0, 0, -1);
    run_job(3, 4, 0, 0, 1);
    run_job(2, 4, 0, 0, -1);
    run_job(1, 255, 0, 0, -1);
    run_job(1023, 1, 0, 0, -1);
`ifdef WGHT_ACC_CTRL_STALL_EN
    run_job(1, 4, 3, 2, -1);
    run_job(2, 4, 3, 2, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
